// File: rtl/alu_issue_unit.sv
// Issue/writeback stage in front of a combinational 32-bit ALU.
// One instruction in flight; 8x32 register file with a direct load port.
module alu_issue_unit (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        InstrValid,
    input  logic [15:0] Instr,
    output logic        InstrReady,
    input  logic        LoadValid,
    input  logic [2:0]  LoadAddr,
    input  logic [31:0] LoadData,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  OpCode,
    output logic [31:0] CarryIn,
    input  logic [31:0] AluOutput,
    input  logic [31:0] AluCarryOut,
    output logic        ResultValid,
    output logic [31:0] Result,
    output logic        OpError,
    output logic        CarryFlag,
    input  logic [2:0]  DbgAddr,
    output logic [31:0] DbgData
);

    typedef enum logic {IDLE, EXEC} state_e;

    state_e      state_q, state_d;
    logic [31:0] rf_q [8];
    logic [31:0] rf_d [8];
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] res_q, res_d;
    logic [2:0]  op_q, op_d, rd_q, rd_d;
    logic        cin_q, cin_d, cf_q, cf_d;
    logic        rv_q, rv_d, err_q, err_d;

    logic [2:0]  in_op, in_rd, in_rs1, in_rs2;
    logic        in_uc, supported;
    logic        unused;

    assign in_op  = Instr[15:13];
    assign in_rd  = Instr[12:10];
    assign in_rs1 = Instr[9:7];
    assign in_rs2 = Instr[6:4];
    assign in_uc  = Instr[3];
    assign unused = ^{Instr[2:0], AluCarryOut[31:1]};

    assign supported = (in_op == 3'b000) || (in_op == 3'b001) ||
                       (in_op == 3'b011) || (in_op == 3'b101);

    always_comb begin
        state_d = state_q;
        rf_d    = rf_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cin_d   = cin_q;
        rd_d    = rd_q;
        cf_d    = cf_q;
        res_d   = res_q;
        rv_d    = 1'b0;
        err_d   = 1'b0;
        if (LoadValid) rf_d[LoadAddr] = LoadData;
        unique case (state_q)
            IDLE: begin
                if (InstrValid) begin
                    if (supported) begin
                        a_d     = rf_q[in_rs1];
                        b_d     = rf_q[in_rs2];
                        op_d    = in_op;
                        cin_d   = in_uc & cf_q;
                        rd_d    = in_rd;
                        state_d = EXEC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                // writeback is applied after the load so it wins on collision
                rf_d[rd_q] = AluOutput;
                res_d      = AluOutput;
                rv_d       = 1'b1;
                if (op_q == 3'b000) cf_d = AluCarryOut[0];
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cin_q   <= 1'b0;
            rd_q    <= '0;
            cf_q    <= 1'b0;
            res_q   <= '0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rf_q    <= rf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cin_q   <= cin_d;
            rd_q    <= rd_d;
            cf_q    <= cf_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
        end
    end

    assign InstrReady  = (state_q == IDLE) && !Reset;
    assign A           = a_q;
    assign B           = b_q;
    assign OpCode      = op_q;
    assign CarryIn     = {31'b0, cin_q};
    assign ResultValid = rv_q;
    assign Result      = res_q;
    assign OpError     = err_q;
    assign CarryFlag   = cf_q;
    assign DbgData     = rf_q[DbgAddr];

endmodule
